// File: rtl/relu_backward_layer.sv
// relu_backward_layer
// Backward-pass ReLU: the forward pass records one "input was > 0" bit per
// channel into a small circular mask store; the backward pass pops those
// masks in the same order and uses them to gate the incoming gradient. A
// single registered output stage drives the downstream gradient port.
//
// Handshake rule used on every port: a transfer happens on a rising edge
// where valid && ready are both high. A producer holding valid keeps its
// data stable until that edge. The ready outputs depend only on registered
// state, rst_n and grad_out_ready, never on any valid input.

module relu_backward_layer #(
    parameter int D_WIDTH  = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fwd_valid,
    output logic                          fwd_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]   fwd_data,
    input  logic                          grad_in_valid,
    output logic                          grad_in_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]   grad_in_data,
    output logic                          grad_out_valid,
    input  logic                          grad_out_ready,
    output logic [D_WIDTH*CHANNELS-1:0]   grad_out_data,
    output logic [$clog2(DEPTH+1)-1:0]    mask_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DATA_W = D_WIDTH * CHANNELS;

    // Mask storage: contents are don't-care until written, so no reset.
    logic [CHANNELS-1:0] mask_mem_q [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [CHANNELS-1:0] fwd_mask;
    logic [CHANNELS-1:0] rd_mask;
    logic                push;
    logic                pop;

    // Readies come from registered state only; rst_n forces them low during reset.
    assign fwd_ready     = rst_n && (count_q != CNT_W'(DEPTH));
    assign grad_in_ready = rst_n && (count_q != '0) && (!out_valid_q || grad_out_ready);

    assign push = fwd_valid && fwd_ready;
    assign pop  = grad_in_valid && grad_in_ready;

    // The store is read at rd_ptr before any same-cycle write lands, so a
    // mask pushed this cycle is never visible to a pop until the next one.
    assign rd_mask = mask_mem_q[rd_ptr_q];

    assign grad_out_valid = out_valid_q;
    assign grad_out_data  = out_data_q;
    assign mask_count     = count_q;

    // Per-channel "strictly positive" test: sign bit clear and value nonzero.
    always_comb begin
        fwd_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            fwd_mask[i] = !fwd_data[D_WIDTH*i + D_WIDTH-1] &&
                          (|fwd_data[D_WIDTH*i +: D_WIDTH]);
        end
    end

    // Pointer advance with explicit wrap from DEPTH-1 back to 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output stage: load gated gradient on pop, otherwise drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                out_data_d[D_WIDTH*i +: D_WIDTH] =
                    rd_mask[i] ? grad_in_data[D_WIDTH*i +: D_WIDTH] : '0;
            end
        end else if (out_valid_q && grad_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Mask write on accepted forward sample.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem_q[wr_ptr_q] <= fwd_mask;
        end
    end

    // Pointers, count and output register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_relu_backward_layer.sv
// Bench for relu_backward_layer: table vectors plus hand-written sequences
// for full/stall/simultaneous/reset corner cases, with a mask model and an
// expected-output queue.

module tb_relu_backward_layer;

    localparam int D_WIDTH  = 16;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;
    localparam int W        = D_WIDTH * CHANNELS;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fwd_valid;
    logic             fwd_ready;
    logic [W-1:0]     fwd_data;
    logic             grad_in_valid;
    logic             grad_in_ready;
    logic [W-1:0]     grad_in_data;
    logic             grad_out_valid;
    logic             grad_out_ready;
    logic [W-1:0]     grad_out_data;
    logic [CNT_W-1:0] mask_count;

    relu_backward_layer #(
        .D_WIDTH (D_WIDTH),
        .CHANNELS(CHANNELS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fwd_valid     (fwd_valid),
        .fwd_ready     (fwd_ready),
        .fwd_data      (fwd_data),
        .grad_in_valid (grad_in_valid),
        .grad_in_ready (grad_in_ready),
        .grad_in_data  (grad_in_data),
        .grad_out_valid(grad_out_valid),
        .grad_out_ready(grad_out_ready),
        .grad_out_data (grad_out_data),
        .mask_count    (mask_count)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] fwd;
        logic [W-1:0] grad;
        logic [W-1:0] req;
    } vec_t;

    vec_t vecs [5];

    logic [W-1:0]          exp_q [$];
    logic [CHANNELS-1:0]   mask_q [$];
    logic                  m_valid;
    int                    n_checks;
    int                    n_fail;

    function automatic logic [W-1:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                           input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [CHANNELS-1:0] mask_of(input logic [W-1:0] d);
        logic [CHANNELS-1:0] m;
        logic signed [D_WIDTH-1:0] v;
        m = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v = d[D_WIDTH*i +: D_WIDTH];
            m[i] = (v > 0);
        end
        return m;
    endfunction

    function automatic logic [W-1:0] apply(input logic [CHANNELS-1:0] m, input logic [W-1:0] g);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (m[i]) r[D_WIDTH*i +: D_WIDTH] = g[D_WIDTH*i +: D_WIDTH];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        return {$urandom(), $urandom()};
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
    task automatic cycle(input logic fv, input logic [W-1:0] fd, input logic gv,
                         input logic [W-1:0] gd, input logic gr);
        logic exp_fr;
        logic exp_gr;
        logic [CHANNELS-1:0] m;
        fwd_valid      = fv;
        fwd_data       = fd;
        grad_in_valid  = gv;
        grad_in_data   = gd;
        grad_out_ready = gr;
        @(negedge clk);
        exp_fr = (mask_q.size() != DEPTH);
        exp_gr = (mask_q.size() != 0) && (!m_valid || gr);
        check("fwd_ready", W'(fwd_ready), W'(exp_fr));
        check("grad_in_ready", W'(grad_in_ready), W'(exp_gr));
        check("mask_count", W'(mask_count), W'(mask_q.size()));
        check("grad_out_valid", W'(grad_out_valid), W'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got output %0h, expected nothing", grad_out_data);
            end else begin
                check("grad_out_data", grad_out_data, exp_q[0]);
                if (gr) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (gv && exp_gr) begin
            m = mask_q.pop_front();
            exp_q.push_back(apply(m, gd));
            m_valid = 1'b1;
        end else if (m_valid && gr) begin
            m_valid = 1'b0;
        end
        if (fv && exp_fr) mask_q.push_back(mask_of(fd));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] g;
        logic [15:0]  p;
        logic [15:0]  n;
        n_checks = 0;
        n_fail   = 0;
        m_valid  = 1'b0;

        vecs[0] = '{pack4(16'd5, 16'd0, 16'hFFFD, 16'h7FFF),
                    pack4(16'd1, 16'd2, 16'd3, 16'd4),
                    pack4(16'd1, 16'd0, 16'd0, 16'd4)};
        vecs[1] = '{pack4(16'h8000, 16'h0001, 16'hFFFF, 16'h0001),
                    pack4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD),
                    pack4(16'h0000, 16'hBBBB, 16'h0000, 16'hDDDD)};
        vecs[2] = '{pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000),
                    pack4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0),
                    pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000)};
        vecs[3] = '{pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
                    pack4(16'h8000, 16'hFFFF, 16'h0001, 16'h0000),
                    pack4(16'h8000, 16'hFFFF, 16'h0001, 16'h0000)};
        vecs[4] = '{pack4(16'h8001, 16'h0100, 16'h0000, 16'hC000),
                    pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444),
                    pack4(16'h0000, 16'h2222, 16'h0000, 16'h0000)};

        // Reset state
        rst_n = 1'b0;
        fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in_data = '0; grad_out_ready = 1'b1;
        #12;
        check("rst_grad_out_valid", W'(grad_out_valid), '0);
        check("rst_grad_out_data", grad_out_data, '0);
        check("rst_mask_count", W'(mask_count), '0);
        check("rst_fwd_ready", W'(fwd_ready), '0);
        check("rst_grad_in_ready", W'(grad_in_ready), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors: push, pop, compare against hand-derived result
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, vecs[k].fwd, 1'b0, '0, 1'b1);
            check("vec_count_after_push", W'(mask_count), W'(1));
            cycle(1'b0, '0, 1'b1, vecs[k].grad, 1'b1);
            check("vec_out_valid", W'(grad_out_valid), W'(1));
            check("vec_out_data", grad_out_data, vecs[k].req);
            check("vec_count_after_pop", W'(mask_count), '0);
            idle(1);
        end

        // Fill past capacity, then drain with constant gradient
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k == 1) cycle(1'b1, pack4(16'h0000, 16'h8000, 16'h0001, 16'h7FFF), 1'b0, '0, 1'b1);
            else cycle(1'b1, rand_w(), 1'b0, '0, 1'b1);
        end
        check("full_count", W'(mask_count), W'(DEPTH));
        check("full_fwd_ready", W'(fwd_ready), '0);
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, '0, 1'b1, {4{16'h0011}}, 1'b1);
        idle(2);

        // Continuous stream across several pointer wraps
        for (int k = 0; k < 4 * DEPTH + 3; k++) begin
            p = 16'($urandom_range(1, 16'h7FFF));
            n = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            if (k % 2 == 0) cycle(1'b1, pack4(p, n, p, n), 1'b1, rand_w(), 1'b1);
            else            cycle(1'b1, pack4(n, p, n, p), 1'b1, rand_w(), 1'b1);
        end
        idle(1);
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b1);
        idle(2);

        // Downstream stall: output held, no mask consumed
        for (int k = 0; k < 3; k++) cycle(1'b1, rand_w(), 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b1);
        g = rand_w();
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, g, 1'b0);
        check("stall_count", W'(mask_count), W'(2));
        cycle(1'b0, '0, 1'b1, g, 1'b1);
        check("stall_release_count", W'(mask_count), W'(1));

        // Simultaneous push and pop with a single stored mask
        cycle(1'b1, pack4(16'h0001, 16'h0001, 16'h0001, 16'h0001), 1'b1, rand_w(), 1'b1);
        check("simul_count", W'(mask_count), W'(1));
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b1);
        idle(1);

        // Empty store: gradients refused
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b1);
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b0);
        check("empty_no_output", W'(grad_out_valid), '0);

        // Asynchronous reset with masks stored and output pending
        for (int k = 0; k < 4; k++) cycle(1'b1, rand_w(), 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grad_out_valid", W'(grad_out_valid), '0);
        check("arst_mask_count", W'(mask_count), '0);
        check("arst_fwd_ready", W'(fwd_ready), '0);
        check("arst_grad_in_ready", W'(grad_in_ready), '0);
        mask_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        grad_out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, rand_w(), 1'b1);
        cycle(1'b1, vecs[0].fwd, 1'b1, vecs[0].grad, 1'b1);
        cycle(1'b0, '0, 1'b1, vecs[0].grad, 1'b1);
        check("post_rst_out", grad_out_data, vecs[0].req);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
